// File: rtl/hram_pkg.sv
// Shared types and constants for the HyperRAM read cache.
package hram_pkg;

  localparam int unsigned HBC_ADDR_W    = 24;
  localparam int unsigned IDX_W_DEF     = 6;
  localparam int unsigned TAG_W         = HBC_ADDR_W - IDX_W_DEF - 2;
  localparam logic [7:0]  HRAM_CFG_SPACE = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM,
    ST_RESP
  } state_t;

endpackage

// File: rtl/hram_cache_ram.sv
// Sync-read tag/data array with byte-granular data writes; one read and one write port.
module hram_cache_ram
  import hram_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [TAG_BITS-1:0] o_rtag,
  output logic [31:0]         o_rdata,
  input  logic                i_we,
  input  logic                i_tag_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [3:0]          i_wbe,
  input  logic [TAG_BITS-1:0] i_wtag,
  input  logic [31:0]         i_wdata
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [TAG_BITS-1:0] r_tag  [DEPTH];
  logic [31:0]         r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && i_tag_we) r_tag[i_waddr] <= i_wtag;
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_wbe[b]) r_data[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    o_rtag  <= r_tag[i_raddr];
    o_rdata <= r_data[i_raddr];
  end

endmodule

// File: rtl/hram_cache.sv
// Direct-mapped write-through read cache between iomem and the HyperBus controller.
// Optional hit/miss statistics counters enabled by defining HRAM_CACHE_STATS_EN.
module hram_cache
  import hram_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned ADDR_W = HBC_ADDR_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  input  logic        s_cfg,
  input  logic [3:0]  s_wstrb,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_ready,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  output logic        m_cfg,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  input  logic        cache_inv,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned DEPTH    = 2 ** IDX_W;
  localparam int unsigned TAG_BITS = ADDR_W - IDX_W - 2;

  state_t              r_state, w_state_nxt;
  logic                r_cfg, w_cfg_nxt;
  logic [3:0]          r_wstrb, w_wstrb_nxt;
  logic [ADDR_W-1:2]   r_addr, w_addr_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic                r_hit, w_hit_nxt;
  logic                r_skip, w_skip_nxt;
  logic                r_inv_pend, w_inv_pend_nxt;
  logic [DEPTH-1:0]    r_valid, w_valid_nxt;
  logic                w_s_ready_nxt, w_m_valid_nxt, w_m_cfg_nxt;
  logic [31:0]         w_s_rdata_nxt, w_m_addr_nxt, w_m_wdata_nxt;
  logic [3:0]          w_m_wstrb_nxt;
  logic                w_hit_inc, w_miss_inc, w_cnt_clr;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_BITS-1:0] w_tag, w_ram_tag;
  logic [31:0]         w_ram_data;
  logic                w_hit;
  logic                w_ram_we, w_ram_tag_we;
  logic [3:0]          w_ram_be;
  logic [31:0]         w_ram_wdata;
  logic                w_unused_addr;

  assign w_unused_addr = ^{s_addr[31:ADDR_W], s_addr[1:0]};
  assign w_idx         = r_addr[IDX_W+1:2];
  assign w_tag         = r_addr[ADDR_W-1:IDX_W+2];
  assign w_hit         = r_valid[w_idx] && (w_ram_tag == w_tag) && !r_cfg;

  // Array is read with the live request address so the lookup result is ready in LOOKUP.
  hram_cache_ram #(.IDX_W(IDX_W), .TAG_BITS(TAG_BITS)) u_ram (
    .clk      (clk),
    .i_raddr  (s_addr[IDX_W+1:2]),
    .o_rtag   (w_ram_tag),
    .o_rdata  (w_ram_data),
    .i_we     (w_ram_we),
    .i_tag_we (w_ram_tag_we),
    .i_waddr  (w_idx),
    .i_wbe    (w_ram_be),
    .i_wtag   (w_tag),
    .i_wdata  (w_ram_wdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cfg      <= 1'b0;
      r_wstrb    <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_hit      <= 1'b0;
      r_skip     <= 1'b0;
      r_inv_pend <= 1'b0;
      r_valid    <= '0;
      s_ready    <= 1'b0;
      s_rdata    <= 32'd0;
      m_valid    <= 1'b0;
      m_cfg      <= 1'b0;
      m_wstrb    <= 4'd0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg      <= w_cfg_nxt;
      r_wstrb    <= w_wstrb_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_hit      <= w_hit_nxt;
      r_skip     <= w_skip_nxt;
      r_inv_pend <= w_inv_pend_nxt;
      r_valid    <= w_valid_nxt;
      s_ready    <= w_s_ready_nxt;
      s_rdata    <= w_s_rdata_nxt;
      m_valid    <= w_m_valid_nxt;
      m_cfg      <= w_m_cfg_nxt;
      m_wstrb    <= w_m_wstrb_nxt;
      m_addr     <= w_m_addr_nxt;
      m_wdata    <= w_m_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cfg_nxt      = r_cfg;
    w_wstrb_nxt    = r_wstrb;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_hit_nxt      = r_hit;
    w_skip_nxt     = 1'b0;
    w_inv_pend_nxt = r_inv_pend;
    w_valid_nxt    = r_valid;
    w_s_ready_nxt  = 1'b0;
    w_s_rdata_nxt  = s_rdata;
    w_m_valid_nxt  = m_valid;
    w_m_cfg_nxt    = m_cfg;
    w_m_wstrb_nxt  = m_wstrb;
    w_m_addr_nxt   = m_addr;
    w_m_wdata_nxt  = m_wdata;
    w_ram_we       = 1'b0;
    w_ram_tag_we   = 1'b0;
    w_ram_be       = 4'd0;
    w_ram_wdata    = 32'd0;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;
    w_cnt_clr      = 1'b0;
    if (cache_inv && r_state != ST_IDLE) w_inv_pend_nxt = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (cache_inv || r_inv_pend) begin
          w_valid_nxt    = '0;
          w_inv_pend_nxt = 1'b0;
          w_cnt_clr      = 1'b1;
        end
        // r_skip masks the late-dropped valid of the request just completed.
        if (s_valid && !r_skip) begin
          w_cfg_nxt   = s_cfg;
          w_wstrb_nxt = s_wstrb;
          w_addr_nxt  = s_addr[ADDR_W-1:2];
          w_wdata_nxt = s_wdata;
          w_state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (r_wstrb == 4'd0 && w_hit) begin
          w_s_rdata_nxt = w_ram_data;
          w_s_ready_nxt = 1'b1;
          w_hit_inc     = 1'b1;
          w_state_nxt   = ST_RESP;
        end else begin
          w_miss_inc    = (r_wstrb == 4'd0) && !r_cfg;
          w_hit_nxt     = w_hit;
          w_m_valid_nxt = 1'b1;
          w_m_cfg_nxt   = r_cfg;
          w_m_wstrb_nxt = r_wstrb;
          w_m_addr_nxt  = {(32 - ADDR_W)'(0), r_addr, 2'b00};
          w_m_wdata_nxt = r_wdata;
          w_state_nxt   = ST_MEM;
        end
      end
      ST_MEM: begin
        if (m_ready) begin
          w_m_valid_nxt = 1'b0;
          w_s_ready_nxt = 1'b1;
          w_state_nxt   = ST_RESP;
          if (r_cfg) begin
            w_s_rdata_nxt = m_rdata;
          end else if (r_wstrb == 4'd0) begin
            w_s_rdata_nxt      = m_rdata;
            w_ram_we           = 1'b1;
            w_ram_tag_we       = 1'b1;
            w_ram_be           = 4'hF;
            w_ram_wdata        = m_rdata;
            w_valid_nxt[w_idx] = 1'b1;
          end else if (r_hit) begin
            w_ram_we    = 1'b1;
            w_ram_be    = r_wstrb;
            w_ram_wdata = r_wdata;
          end
        end
      end
      ST_RESP: begin
        w_skip_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef HRAM_CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Saturating read statistics; cleared alongside the valid bits.
  always_ff @(posedge clk) begin
    if (!resetn || w_cnt_clr) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_hit_inc && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss_inc && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^{w_hit_inc, w_miss_inc, w_cnt_clr};
  assign hit_cnt      = 32'd0;
  assign miss_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_hram_cache.sv
// Scoreboard bench for hram_cache: drives iomem requests, emulates the hbc port, checks read data.
module tb_hram_cache;
  import hram_pkg::*;

  logic        clk, resetn;
  logic        s_valid, s_cfg, s_ready;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        m_valid, m_cfg, m_ready;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        cache_inv;
  logic [31:0] hit_cnt, miss_cnt;

  int          n_chk, n_pass;
  int          e_hit, e_miss;
  logic [31:0] q_exp[$];

  hram_cache dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid   (s_valid),
    .s_cfg     (s_cfg),
    .s_wstrb   (s_wstrb),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .m_valid   (m_valid),
    .m_cfg     (m_cfg),
    .m_wstrb   (m_wstrb),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .cache_inv (cache_inv),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic check_cnt(input string tag);
`ifdef HRAM_CACHE_STATS_EN
    check({tag, "_hit_cnt"}, hit_cnt, 32'(e_hit));
    check({tag, "_miss_cnt"}, miss_cnt, 32'(e_miss));
`else
    check({tag, "_hit_cnt"}, hit_cnt, 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, 32'd0);
`endif
  endtask

  // One iomem transaction; called and returning on a negedge.
  task automatic txn(input string tag, input logic cfg, input logic [3:0] wstrb,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic exp_mreq,
                     input logic [31:0] mem_rd, input logic [31:0] exp_rd, input logic inv_mid);
    int          cyc;
    logic        seen_m, got_rdy, quiet;
    logic [31:0] d;
    cyc = 0; seen_m = 1'b0; got_rdy = 1'b0; quiet = 1'b1;
    if (wstrb == 4'd0) q_exp.push_back(exp_rd);
    s_valid = 1'b1; s_cfg = cfg; s_wstrb = wstrb; s_addr = addr; s_wdata = wdata;
    while (!got_rdy && cyc < 200) begin
      @(negedge clk); cyc++;
      m_ready = 1'b0;
      if (s_ready) begin
        got_rdy = 1'b1;
        if (wstrb == 4'd0 && q_exp.size() > 0) begin
          d = q_exp.pop_front();
          check({tag, "_rdata"}, s_rdata, d);
        end
        if (!exp_mreq) check({tag, "_hit_lat"}, 32'(cyc), 32'd2);
      end else if (m_valid && !seen_m) begin
        seen_m = 1'b1;
        check({tag, "_m_addr"}, m_addr, {8'h00, addr[23:2], 2'b00});
        check({tag, "_m_cfg"}, 32'(m_cfg), 32'(cfg));
        check({tag, "_m_wstrb"}, 32'(m_wstrb), 32'(wstrb));
        if (wstrb != 4'd0) check({tag, "_m_wdata"}, m_wdata, wdata);
        for (int i = 0; i < 3; i++) begin
          cache_inv = inv_mid && (i == 0);
          @(negedge clk); cyc++;
        end
        cache_inv = 1'b0;
        check({tag, "_m_hold"}, 32'(m_valid), 32'd1);
        m_ready = 1'b1; m_rdata = mem_rd;
      end
    end
    check({tag, "_done"}, 32'(got_rdy), 32'd1);
    if (!got_rdy && wstrb == 4'd0 && q_exp.size() > 0) d = q_exp.pop_front();
    check({tag, "_mreq"}, 32'(seen_m), 32'(exp_mreq));
    // Hold valid across the post-response cycle to mimic the late drop.
    @(negedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (s_ready || m_valid) quiet = 1'b0;
    end
    check({tag, "_quiet"}, 32'(quiet), 32'd1);
    if (!cfg && wstrb == 4'd0) begin
      if (exp_mreq) e_miss++;
      else e_hit++;
    end
    if (inv_mid) begin e_hit = 0; e_miss = 0; end
    check_cnt(tag);
  endtask

  initial begin
    logic [31:0] cfg_addr;
    n_chk = 0; n_pass = 0; e_hit = 0; e_miss = 0;
    resetn = 1'b0; s_valid = 1'b0; s_cfg = 1'b0; s_wstrb = 4'd0; s_addr = 32'd0;
    s_wdata = 32'd0; m_ready = 1'b0; m_rdata = 32'd0; cache_inv = 1'b0;
    cfg_addr = {HRAM_CFG_SPACE, 24'h000000};
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_s_rdata", s_rdata, 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wstrb", 32'(m_wstrb), 32'd0);
    check_cnt("rst");
    resetn = 1'b1;
    @(negedge clk);

    txn("cold_rd",   1'b0, 4'd0,    32'h0000_0100, 32'd0,         1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    txn("hit_rd",    1'b0, 4'd0,    32'h0000_0100, 32'd0,         1'b0, 32'd0,         32'hDEAD_BEEF, 1'b0);
    txn("wr_hit",    1'b0, 4'b0010, 32'h0000_0100, 32'h0000_5500, 1'b1, 32'd0,         32'd0,         1'b0);
    txn("merge_rd",  1'b0, 4'd0,    32'h0000_0100, 32'd0,         1'b0, 32'd0,         32'hDEAD_55EF, 1'b0);
    txn("alias_rd",  1'b0, 4'd0,    32'h0000_0200, 32'd0,         1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
    txn("evict_rd",  1'b0, 4'd0,    32'h0000_0100, 32'd0,         1'b1, 32'hDEAD_55EF, 32'hDEAD_55EF, 1'b0);
    txn("rehit_rd",  1'b0, 4'd0,    32'h0000_0100, 32'd0,         1'b0, 32'd0,         32'hDEAD_55EF, 1'b0);
    txn("cfg_rd1",   1'b1, 4'd0,    cfg_addr,      32'd0,         1'b1, 32'h0000_0ABC, 32'h0000_0ABC, 1'b0);
    txn("cfg_rd2",   1'b1, 4'd0,    cfg_addr,      32'd0,         1'b1, 32'h0000_0DEF, 32'h0000_0DEF, 1'b0);
    txn("wr_miss",   1'b0, 4'hF,    32'h0000_0300, 32'h1111_2222, 1'b1, 32'd0,         32'd0,         1'b0);
    txn("noalloc",   1'b0, 4'd0,    32'h0000_0300, 32'd0,         1'b1, 32'h1111_2222, 32'h1111_2222, 1'b0);
    txn("inv_fill",  1'b0, 4'd0,    32'h0000_0104, 32'd0,         1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
    txn("post_inv",  1'b0, 4'd0,    32'h0000_0104, 32'd0,         1'b1, 32'h5A5A_0001, 32'h5A5A_0001, 1'b0);
    txn("fill_hit",  1'b0, 4'd0,    32'h0000_0104, 32'd0,         1'b0, 32'd0,         32'h5A5A_0001, 1'b0);

    // Invalidate while idle: every line, including the one just filled, must miss.
    cache_inv = 1'b1;
    @(negedge clk);
    cache_inv = 1'b0;
    e_hit = 0; e_miss = 0;
    check_cnt("idle_inv");
    txn("idle_inv",  1'b0, 4'd0,    32'h0000_0104, 32'd0,         1'b1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0);
    txn("idle_inv2", 1'b0, 4'd0,    32'h0000_0200, 32'd0,         1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);

    check("sb_empty", 32'(q_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
